// File: rtl/rob_fifo_multi_if.sv
// Bundle of dispatch, CDB, operand-lookup and retire signals for the reorder buffer.
// The ROB side uses the slave modport; dispatch/CDB/commit drive through master.
interface rob_fifo_multi_if #(
    parameter int DEPTH    = 64,
    parameter int TAG_W    = $clog2(DEPTH),
    parameter int DATA_W   = 32,
    parameter int NUM_CDB  = 2,
    parameter int RETIRE_W = 2
);
    logic                         flush;
    logic                         alloc_valid;
    logic [4:0]                   alloc_rd;
    logic                         alloc_is_store;
    logic                         alloc_is_branch;
    logic                         alloc_ready;
    logic [TAG_W-1:0]             alloc_tag;
    logic [NUM_CDB-1:0]           cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]     cdb_tag;
    logic [NUM_CDB*DATA_W-1:0]    cdb_result;
    logic [NUM_CDB*DATA_W-1:0]    cdb_store_data;
    logic [NUM_CDB-1:0]           cdb_branch_taken;
    logic [TAG_W-1:0]             rs1_tag;
    logic [TAG_W-1:0]             rs2_tag;
    logic [DATA_W-1:0]            rs1_data;
    logic [DATA_W-1:0]            rs2_data;
    logic                         rs1_ready;
    logic                         rs2_ready;
    logic                         retire_stall;
    logic [RETIRE_W-1:0]          retire_valid;
    logic [RETIRE_W*5-1:0]        retire_rd;
    logic [RETIRE_W*DATA_W-1:0]   retire_data;
    logic [RETIRE_W*DATA_W-1:0]   retire_store_data;
    logic [RETIRE_W-1:0]          retire_is_store;
    logic [RETIRE_W-1:0]          retire_is_branch;
    logic [RETIRE_W-1:0]          retire_branch_taken;
    logic [TAG_W:0]               count;
    logic                         empty;

    modport master (
        output flush, alloc_valid, alloc_rd, alloc_is_store, alloc_is_branch,
               cdb_valid, cdb_tag, cdb_result, cdb_store_data, cdb_branch_taken,
               rs1_tag, rs2_tag, retire_stall,
        input  alloc_ready, alloc_tag, rs1_data, rs2_data, rs1_ready, rs2_ready,
               retire_valid, retire_rd, retire_data, retire_store_data,
               retire_is_store, retire_is_branch, retire_branch_taken, count, empty
    );

    modport slave (
        input  flush, alloc_valid, alloc_rd, alloc_is_store, alloc_is_branch,
               cdb_valid, cdb_tag, cdb_result, cdb_store_data, cdb_branch_taken,
               rs1_tag, rs2_tag, retire_stall,
        output alloc_ready, alloc_tag, rs1_data, rs2_data, rs1_ready, rs2_ready,
               retire_valid, retire_rd, retire_data, retire_store_data,
               retire_is_store, retire_is_branch, retire_branch_taken, count, empty
    );
endinterface

// File: rtl/rob_fifo_multi.sv
// Circular reorder buffer: in-order allocate, NUM_CDB completions per cycle, up to RETIRE_W in-order retires.
// Define ROB_CDB_BYPASS_EN to forward same-cycle CDB results onto the operand lookup ports.
module rob_fifo_multi #(
    parameter int DEPTH    = 64,
    parameter int TAG_W    = $clog2(DEPTH),
    parameter int DATA_W   = 32,
    parameter int NUM_CDB  = 2,
    parameter int RETIRE_W = 2
) (
    input  logic               clk,
    input  logic               i_rst_n,
    rob_fifo_multi_if.slave    bus
);
    localparam int PTR_W = TAG_W + 1;

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_spec_valid;
    logic [DEPTH-1:0]  r_is_store;
    logic [DEPTH-1:0]  r_is_branch;
    logic [DEPTH-1:0]  r_br_taken;
    logic [4:0]        r_rd         [DEPTH];
    logic [DATA_W-1:0] r_spec_data  [DEPTH];
    logic [DATA_W-1:0] r_store_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W-1:0]  r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_alloc_fire;
    logic              w_slot0_ok;
    logic [RETIRE_W-1:0] w_ret_ok;
    logic [TAG_W-1:0]  w_slot_idx [RETIRE_W];
    logic [PTR_W-1:0]  w_retire_num;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign w_empty      = (r_head == r_tail);
    assign w_full       = (r_head[TAG_W-1:0] == r_tail[TAG_W-1:0]) && (r_head[TAG_W] != r_tail[TAG_W]);
    assign w_alloc_fire = bus.alloc_valid && !w_full;

    assign bus.alloc_ready = !w_full;
    assign bus.alloc_tag   = r_tail[TAG_W-1:0];
    assign bus.count       = r_count;
    assign bus.empty       = w_empty;

    assign w_slot0_ok = !bus.retire_stall && !w_empty
                        && r_valid[w_slot_idx[0]] && r_spec_valid[w_slot_idx[0]];

    genvar gi;
    generate
        for (gi = 0; gi < RETIRE_W; gi++) begin : g_slot
            assign w_slot_idx[gi] = r_head[TAG_W-1:0] + TAG_W'(gi);
            if (gi == 0) begin : g_first
                assign w_ret_ok[gi] = w_slot0_ok;
            end else begin : g_second
                // Only one store may reach the store path per cycle.
                assign w_ret_ok[gi] = w_slot0_ok && (r_count >= PTR_W'(2))
                                      && r_valid[w_slot_idx[gi]] && r_spec_valid[w_slot_idx[gi]]
                                      && !(r_is_store[w_slot_idx[0]] && r_is_store[w_slot_idx[gi]]);
            end
            assign bus.retire_valid[gi]                      = w_ret_ok[gi];
            assign bus.retire_rd[gi*5 +: 5]                  = w_ret_ok[gi] ? r_rd[w_slot_idx[gi]] : 5'd0;
            assign bus.retire_data[gi*DATA_W +: DATA_W]      = w_ret_ok[gi] ? r_spec_data[w_slot_idx[gi]] : '0;
            assign bus.retire_store_data[gi*DATA_W +: DATA_W] = w_ret_ok[gi] ? r_store_data[w_slot_idx[gi]] : '0;
            assign bus.retire_is_store[gi]                   = w_ret_ok[gi] && r_is_store[w_slot_idx[gi]];
            assign bus.retire_is_branch[gi]                  = w_ret_ok[gi] && r_is_branch[w_slot_idx[gi]];
            assign bus.retire_branch_taken[gi]               = w_ret_ok[gi] && r_br_taken[w_slot_idx[gi]];
        end
    endgenerate

    always_comb begin
        w_retire_num = '0;
        for (int k = 0; k < RETIRE_W; k++) begin
            w_retire_num = w_retire_num + PTR_W'(w_ret_ok[k]);
        end
    end

    always_comb begin
        bus.rs1_data  = r_spec_data[bus.rs1_tag];
        bus.rs1_ready = r_valid[bus.rs1_tag] && r_spec_valid[bus.rs1_tag];
        bus.rs2_data  = r_spec_data[bus.rs2_tag];
        bus.rs2_ready = r_valid[bus.rs2_tag] && r_spec_valid[bus.rs2_tag];
`ifdef ROB_CDB_BYPASS_EN
        // Ascending scan so the highest matching port wins.
        for (int p = 0; p < NUM_CDB; p++) begin
            if (bus.cdb_valid[p] && bus.cdb_tag[p*TAG_W +: TAG_W] == bus.rs1_tag && r_valid[bus.rs1_tag]) begin
                bus.rs1_data  = bus.cdb_result[p*DATA_W +: DATA_W];
                bus.rs1_ready = 1'b1;
            end
            if (bus.cdb_valid[p] && bus.cdb_tag[p*TAG_W +: TAG_W] == bus.rs2_tag && r_valid[bus.rs2_tag]) begin
                bus.rs2_data  = bus.cdb_result[p*DATA_W +: DATA_W];
                bus.rs2_ready = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_valid      <= '0;
            r_spec_valid <= '0;
            r_is_store   <= '0;
            r_is_branch  <= '0;
            r_br_taken   <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_rd[e]         <= '0;
                r_spec_data[e]  <= '0;
                r_store_data[e] <= '0;
            end
        end else if (bus.flush) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_valid      <= '0;
            r_spec_valid <= '0;
        end else begin
            // Later ports overwrite earlier ones on a shared tag.
            for (int p = 0; p < NUM_CDB; p++) begin
                if (bus.cdb_valid[p] && r_valid[bus.cdb_tag[p*TAG_W +: TAG_W]]) begin
                    r_spec_valid[bus.cdb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
                    r_spec_data[bus.cdb_tag[p*TAG_W +: TAG_W]]  <= bus.cdb_result[p*DATA_W +: DATA_W];
                    r_store_data[bus.cdb_tag[p*TAG_W +: TAG_W]] <= bus.cdb_store_data[p*DATA_W +: DATA_W];
                    r_br_taken[bus.cdb_tag[p*TAG_W +: TAG_W]]   <= bus.cdb_branch_taken[p];
                end
            end
            for (int k = 0; k < RETIRE_W; k++) begin
                if (w_ret_ok[k]) begin
                    r_valid[w_slot_idx[k]]      <= 1'b0;
                    r_spec_valid[w_slot_idx[k]] <= 1'b0;
                end
            end
            if (w_alloc_fire) begin
                r_valid[r_tail[TAG_W-1:0]]      <= 1'b1;
                r_spec_valid[r_tail[TAG_W-1:0]] <= 1'b0;
                r_rd[r_tail[TAG_W-1:0]]         <= bus.alloc_rd;
                r_is_store[r_tail[TAG_W-1:0]]   <= bus.alloc_is_store;
                r_is_branch[r_tail[TAG_W-1:0]]  <= bus.alloc_is_branch;
                r_br_taken[r_tail[TAG_W-1:0]]   <= 1'b0;
            end
            r_tail  <= r_tail + PTR_W'(w_alloc_fire);
            r_head  <= r_head + w_retire_num;
            r_count <= r_count + PTR_W'(w_alloc_fire) - w_retire_num;
        end
    end
endmodule

// File: tb/tb_rob_fifo_multi.sv
// Self-checking bench for rob_fifo_multi: directed scenarios plus randomized traffic
// checked against a queue-based model of the reorder buffer.
module tb_rob_fifo_multi;
    localparam int DEPTH    = 64;
    localparam int TAG_W    = 6;
    localparam int DATA_W   = 32;
    localparam int NUM_CDB  = 2;
    localparam int RETIRE_W = 2;

    logic clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 clk = ~clk;

    rob_fifo_multi_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W),
                        .NUM_CDB(NUM_CDB), .RETIRE_W(RETIRE_W)) bus ();
    rob_fifo_multi #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W),
                     .NUM_CDB(NUM_CDB), .RETIRE_W(RETIRE_W)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .bus(bus));

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]        rd;
        bit                st;
        bit                br;
        bit                done;
        bit                tk;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] sd;
    } ent_t;

    // Model: oldest entry at q[0]; m_head is the head pointer including wrap (0..2*DEPTH-1).
    ent_t q[$];
    int   m_head = 0;

    function automatic int m_tail_tag();
        return (m_head + q.size()) % DEPTH;
    endfunction

    function automatic int m_nret();
        int n;
        if (bus.retire_stall || q.size() == 0 || !q[0].done) return 0;
        n = 1;
        if (q.size() >= 2 && q[1].done && !(q[0].st && q[1].st)) n = 2;
        return n;
    endfunction

    function automatic void rs_exp(input logic [TAG_W-1:0] tag, output bit rdy, output logic [DATA_W-1:0] d);
        int idx;
        idx = (int'(tag) - m_head + 2*DEPTH) % DEPTH;
        rdy = 1'b0;
        d   = '0;
        if (idx < q.size() && q[idx].done) begin
            rdy = 1'b1;
            d   = q[idx].d;
        end
`ifdef ROB_CDB_BYPASS_EN
        if (idx < q.size()) begin
            for (int p = 0; p < NUM_CDB; p++) begin
                if (bus.cdb_valid[p] && bus.cdb_tag[p*TAG_W +: TAG_W] == tag) begin
                    rdy = 1'b1;
                    d   = bus.cdb_result[p*DATA_W +: DATA_W];
                end
            end
        end
`endif
    endfunction

    task automatic idle_inputs();
        bus.flush            = 1'b0;
        bus.alloc_valid      = 1'b0;
        bus.alloc_rd         = '0;
        bus.alloc_is_store   = 1'b0;
        bus.alloc_is_branch  = 1'b0;
        bus.cdb_valid        = '0;
        bus.cdb_tag          = '0;
        bus.cdb_result       = '0;
        bus.cdb_store_data   = '0;
        bus.cdb_branch_taken = '0;
        bus.retire_stall     = 1'b0;
    endtask

    task automatic set_cdb(input int p, input int tag, input logic [DATA_W-1:0] res,
                           input logic [DATA_W-1:0] sd, input bit tk);
        bus.cdb_valid[p]                      = 1'b1;
        bus.cdb_tag[p*TAG_W +: TAG_W]         = TAG_W'(tag);
        bus.cdb_result[p*DATA_W +: DATA_W]    = res;
        bus.cdb_store_data[p*DATA_W +: DATA_W] = sd;
        bus.cdb_branch_taken[p]               = tk;
    endtask

    // Advance one clock and apply the same cycle to the model.
    task automatic tick();
        int   n;
        int   idx;
        bit   do_alloc;
        ent_t e;
        n        = m_nret();
        do_alloc = bus.alloc_valid && (q.size() < DEPTH);
        @(posedge clk);
        if (bus.flush) begin
            q.delete();
            m_head = 0;
        end else begin
            for (int p = 0; p < NUM_CDB; p++) begin
                if (bus.cdb_valid[p]) begin
                    idx = (int'(bus.cdb_tag[p*TAG_W +: TAG_W]) - m_head + 2*DEPTH) % DEPTH;
                    if (idx < q.size()) begin
                        e      = q[idx];
                        e.done = 1'b1;
                        e.d    = bus.cdb_result[p*DATA_W +: DATA_W];
                        e.sd   = bus.cdb_store_data[p*DATA_W +: DATA_W];
                        e.tk   = bus.cdb_branch_taken[p];
                        q[idx] = e;
                    end
                end
            end
            for (int k = 0; k < n; k++) void'(q.pop_front());
            m_head = (m_head + n) % (2*DEPTH);
            if (do_alloc) begin
                e.rd = bus.alloc_rd; e.st = bus.alloc_is_store; e.br = bus.alloc_is_branch;
                e.done = 1'b0; e.tk = 1'b0; e.d = '0; e.sd = '0;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.rs1_tag = '0;
        bus.rs2_tag = '0;
        #12;
        n_cmp++; if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready got %b want 1", bus.alloc_ready); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        n_cmp++; if (bus.count !== 7'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_cmp++; if (bus.alloc_tag !== 6'd0) begin n_fail++; $display("FAIL reset_alloc_tag got %0d want 0", bus.alloc_tag); end
        n_cmp++; if (bus.retire_valid !== 2'b00) begin n_fail++; $display("FAIL reset_retire_valid got %b want 00", bus.retire_valid); end
        n_cmp++; if (bus.retire_data !== '0 || bus.retire_rd !== '0) begin n_fail++; $display("FAIL reset_retire_data got %h/%h want 0", bus.retire_data, bus.retire_rd); end
        n_cmp++; if (bus.rs1_ready !== 1'b0 || bus.rs1_data !== '0) begin n_fail++; $display("FAIL reset_rs1 got %b/%h want 0/0", bus.rs1_ready, bus.rs1_data); end
        @(negedge clk);
        i_rst_n = 1'b1;
        q.delete();
        m_head = 0;
        $display("reset released");
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            idle_inputs();
            bus.alloc_valid = 1'b1;
            bus.alloc_rd    = i[4:0];
            #1;
            n_cmp++; if (bus.alloc_tag !== TAG_W'(i) || bus.alloc_ready !== 1'b1) begin
                n_fail++; $display("FAIL fill_tag got %0d/%b want %0d/1", bus.alloc_tag, bus.alloc_ready, i); end
            $display("alloc tag %0d", bus.alloc_tag);
            tick();
        end
        #1;
        n_cmp++; if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_alloc_ready got %b want 0", bus.alloc_ready); end
        n_cmp++; if (bus.count !== 7'd64) begin n_fail++; $display("FAIL full_count got %0d want 64", bus.count); end
        tick();
        n_cmp++; if (bus.count !== 7'd64 || bus.alloc_tag !== 6'd0) begin
            n_fail++; $display("FAIL alloc_when_full got count %0d tag %0d want 64/0", bus.count, bus.alloc_tag); end
        idle_inputs();
        bus.flush = 1'b1;
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (bus.count !== 7'd0 || bus.empty !== 1'b1) begin
            n_fail++; $display("FAIL fill_flush got count %0d empty %b want 0/1", bus.count, bus.empty); end
    endtask

    task automatic test_inorder_pair();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            bus.alloc_valid = 1'b1;
            bus.alloc_rd    = 5'(5 + i);
            tick();
        end
        idle_inputs();
        set_cdb(0, 1, 32'h11, '0, 1'b0);
        #1;
        n_cmp++; if (bus.retire_valid !== 2'b00) begin n_fail++; $display("FAIL pair_cdb1_same got %b want 00", bus.retire_valid); end
        tick();
        idle_inputs();
        set_cdb(0, 0, 32'h10, '0, 1'b0);
        #1;
        n_cmp++; if (bus.retire_valid !== 2'b00) begin n_fail++; $display("FAIL pair_head_pending got %b want 00", bus.retire_valid); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (bus.retire_valid !== 2'b11) begin n_fail++; $display("FAIL pair_retire_valid got %b want 11", bus.retire_valid); end
        n_cmp++; if (bus.retire_data !== {32'h11, 32'h10}) begin n_fail++; $display("FAIL pair_retire_data got %h want 0000001100000010", bus.retire_data); end
        n_cmp++; if (bus.retire_rd !== {5'd6, 5'd5}) begin n_fail++; $display("FAIL pair_retire_rd got %h want %h", bus.retire_rd, {5'd6, 5'd5}); end
        $display("retire pair data %h", bus.retire_data);
        tick();
        #1;
        n_cmp++; if (bus.count !== 7'd1) begin n_fail++; $display("FAIL pair_count got %0d want 1", bus.count); end
        set_cdb(0, 2, 32'h12, '0, 1'b0);
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (bus.retire_valid !== 2'b01 || bus.retire_data[31:0] !== 32'h12) begin
            n_fail++; $display("FAIL pair_tail_retire got %b/%h want 01/12", bus.retire_valid, bus.retire_data[31:0]); end
        tick();
        #1;
        n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL pair_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_store_serial();
        int t0;
        t0 = m_tail_tag();
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            bus.alloc_valid    = 1'b1;
            bus.alloc_is_store = 1'b1;
            bus.alloc_rd       = 5'(7 + i);
            tick();
        end
        idle_inputs();
        set_cdb(0, t0, 32'hA0, 32'hD0, 1'b0);
        set_cdb(1, (t0 + 1) % DEPTH, 32'hA1, 32'hD1, 1'b0);
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (bus.retire_valid !== 2'b01 || bus.retire_is_store !== 2'b01) begin
            n_fail++; $display("FAIL store1_valid got %b/%b want 01/01", bus.retire_valid, bus.retire_is_store); end
        n_cmp++; if (bus.retire_store_data !== {32'h0, 32'hD0} || bus.retire_data[31:0] !== 32'hA0) begin
            n_fail++; $display("FAIL store1_data got %h/%h want D0/A0", bus.retire_store_data, bus.retire_data[31:0]); end
        $display("retire store addr %h data %h", bus.retire_data[31:0], bus.retire_store_data[31:0]);
        tick();
        #1;
        n_cmp++; if (bus.retire_valid !== 2'b01 || bus.retire_is_store !== 2'b01) begin
            n_fail++; $display("FAIL store2_valid got %b/%b want 01/01", bus.retire_valid, bus.retire_is_store); end
        n_cmp++; if (bus.retire_store_data !== {32'h0, 32'hD1} || bus.retire_data[31:0] !== 32'hA1) begin
            n_fail++; $display("FAIL store2_data got %h/%h want D1/A1", bus.retire_store_data, bus.retire_data[31:0]); end
        $display("retire store addr %h data %h", bus.retire_data[31:0], bus.retire_store_data[31:0]);
        tick();
        #1;
        n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL store_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_wrap();
        int guard;
        int n;
        guard = 0;
        while (!(m_head == 62 && q.size() == 0) && guard < 400) begin
            idle_inputs();
            if ((m_head + q.size()) % (2*DEPTH) != 62) bus.alloc_valid = 1'b1;
            for (int i = 0; i < q.size(); i++) begin
                if (!q[i].done) begin
                    set_cdb(0, (m_head + i) % DEPTH, 32'h5, '0, 1'b0);
                    break;
                end
            end
            tick();
            guard++;
        end
        n_cmp++; if (guard >= 400) begin n_fail++; $display("FAIL wrap_setup got %0d cycles want <400", guard); end
        for (int i = 0; i < DEPTH; i++) begin
            idle_inputs();
            bus.alloc_valid = 1'b1;
            bus.alloc_rd    = 5'((62 + i) % DEPTH);
            #1;
            n_cmp++; if (bus.alloc_tag !== TAG_W'((62 + i) % DEPTH)) begin
                n_fail++; $display("FAIL wrap_tag got %0d want %0d", bus.alloc_tag, (62 + i) % DEPTH); end
            tick();
        end
        idle_inputs();
        #1;
        n_cmp++; if (bus.count !== 7'd64 || bus.alloc_ready !== 1'b0) begin
            n_fail++; $display("FAIL wrap_full got %0d/%b want 64/0", bus.count, bus.alloc_ready); end
        for (int c = 0; c < 40; c++) begin
            idle_inputs();
            if (c < 32) begin
                set_cdb(0, (62 + 2*c) % DEPTH, 32'h100 + 32'((62 + 2*c) % DEPTH), '0, 1'b0);
                set_cdb(1, (63 + 2*c) % DEPTH, 32'h100 + 32'((63 + 2*c) % DEPTH), '0, 1'b0);
            end
            #1;
            n = m_nret();
            n_cmp++; if (bus.retire_valid !== 2'((1 << n) - 1)) begin
                n_fail++; $display("FAIL wrap_retire_valid got %b want %0d slots", bus.retire_valid, n); end
            for (int k = 0; k < n; k++) begin
                n_cmp++; if (bus.retire_data[k*DATA_W +: DATA_W] !== q[k].d || bus.retire_rd[k*5 +: 5] !== q[k].rd) begin
                    n_fail++; $display("FAIL wrap_retire_slot%0d got %h/%0d want %h/%0d", k,
                        bus.retire_data[k*DATA_W +: DATA_W], bus.retire_rd[k*5 +: 5], q[k].d, q[k].rd); end
                $display("retire slot%0d tag %0d data %h", k, (m_head + k) % DEPTH, bus.retire_data[k*DATA_W +: DATA_W]);
            end
            tick();
        end
        #1;
        n_cmp++; if (bus.empty !== 1'b1 || bus.count !== 7'd0 || bus.alloc_tag !== 6'd62) begin
            n_fail++; $display("FAIL wrap_end got empty %b count %0d tag %0d want 1/0/62", bus.empty, bus.count, bus.alloc_tag); end
    endtask

    task automatic test_flush();
        idle_inputs();
        bus.flush = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            bus.alloc_valid = 1'b1;
            tick();
        end
        idle_inputs();
        set_cdb(0, 0, 32'h30, '0, 1'b0);
        tick();
        idle_inputs();
        bus.flush       = 1'b1;
        bus.alloc_valid = 1'b1;
        set_cdb(0, 3, 32'h33, '0, 1'b0);
        #1;
        n_cmp++; if (bus.retire_valid[0] !== 1'b1) begin n_fail++; $display("FAIL flush_cycle_retire got %b want 1", bus.retire_valid[0]); end
        tick();
        idle_inputs();
        bus.rs1_tag = 6'd3;
        #1;
        n_cmp++; if (bus.count !== 7'd0 || bus.empty !== 1'b1) begin
            n_fail++; $display("FAIL flush_state got count %0d empty %b want 0/1", bus.count, bus.empty); end
        n_cmp++; if (bus.alloc_tag !== 6'd0 || bus.retire_valid !== 2'b00 || bus.rs1_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_ptrs got tag %0d retire %b rs1 %b want 0/00/0", bus.alloc_tag, bus.retire_valid, bus.rs1_ready); end
        $display("flush done");
    endtask

    task automatic test_bypass();
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            bus.alloc_valid = 1'b1;
            tick();
        end
        idle_inputs();
        bus.rs1_tag = 6'd5;
        bus.rs2_tag = 6'd4;
        set_cdb(0, 5, 32'hABCD, '0, 1'b0);
        #1;
`ifdef ROB_CDB_BYPASS_EN
        n_cmp++; if (bus.rs1_ready !== 1'b1 || bus.rs1_data !== 32'hABCD) begin
            n_fail++; $display("FAIL bypass_same_cycle got %b/%h want 1/ABCD", bus.rs1_ready, bus.rs1_data); end
`else
        n_cmp++; if (bus.rs1_ready !== 1'b0) begin
            n_fail++; $display("FAIL nobypass_same_cycle got %b want 0", bus.rs1_ready); end
`endif
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (bus.rs1_ready !== 1'b1 || bus.rs1_data !== 32'hABCD) begin
            n_fail++; $display("FAIL operand_next_cycle got %b/%h want 1/ABCD", bus.rs1_ready, bus.rs1_data); end
        n_cmp++; if (bus.rs2_ready !== 1'b0) begin n_fail++; $display("FAIL operand_pending got %b want 0", bus.rs2_ready); end
        $display("operand tag 5 data %h", bus.rs1_data);
        bus.flush = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int   t;
        int   n;
        bit   dup;
        bit   r1;
        bit   r2;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic [RETIRE_W-1:0] ev, est, ebr, etk;
        logic [RETIRE_W*5-1:0] erd;
        logic [RETIRE_W*DATA_W-1:0] ed, esd;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle_inputs();
            bus.flush           = ($urandom_range(0, 59) == 0);
            bus.alloc_valid     = ($urandom_range(0, 3) != 0);
            bus.alloc_rd        = 5'($urandom);
            bus.alloc_is_store  = ($urandom_range(0, 2) == 0);
            bus.alloc_is_branch = ($urandom_range(0, 3) == 0);
            bus.retire_stall    = ($urandom_range(0, 4) == 0);
            for (int p = 0; p < NUM_CDB; p++) begin
                if ($urandom_range(0, 2) != 0) begin
                    if (q.size() > 0 && $urandom_range(0, 3) != 0)
                        t = (m_head + $urandom_range(0, q.size() - 1)) % DEPTH;
                    else
                        t = $urandom_range(0, DEPTH - 1);
                    dup = 1'b0;
                    for (int pp = 0; pp < p; pp++)
                        if (bus.cdb_valid[pp] && int'(bus.cdb_tag[pp*TAG_W +: TAG_W]) == t) dup = 1'b1;
                    if (!dup) set_cdb(p, t, $urandom, $urandom, 1'($urandom_range(0, 1)));
                end
            end
            bus.rs1_tag = (bus.cdb_valid[0] && $urandom_range(0, 1) == 1) ? bus.cdb_tag[TAG_W-1:0] : TAG_W'($urandom);
            bus.rs2_tag = TAG_W'($urandom);
            #1;
            n_cmp++; if (bus.alloc_ready !== (q.size() < DEPTH) || bus.alloc_tag !== TAG_W'(m_tail_tag())) begin
                n_fail++; $display("FAIL rnd_alloc got %b/%0d want %b/%0d", bus.alloc_ready, bus.alloc_tag, q.size() < DEPTH, m_tail_tag()); end
            n_cmp++; if (bus.count !== (TAG_W+1)'(q.size()) || bus.empty !== (q.size() == 0)) begin
                n_fail++; $display("FAIL rnd_count got %0d/%b want %0d", bus.count, bus.empty, q.size()); end
            n = m_nret();
            ev = '0; est = '0; ebr = '0; etk = '0; erd = '0; ed = '0; esd = '0;
            for (int k = 0; k < n; k++) begin
                ev[k] = 1'b1; est[k] = q[k].st; ebr[k] = q[k].br; etk[k] = q[k].tk;
                erd[k*5 +: 5] = q[k].rd; ed[k*DATA_W +: DATA_W] = q[k].d; esd[k*DATA_W +: DATA_W] = q[k].sd;
            end
            n_cmp++; if (bus.retire_valid !== ev || bus.retire_rd !== erd) begin
                n_fail++; $display("FAIL rnd_retire_valid got %b/%h want %b/%h", bus.retire_valid, bus.retire_rd, ev, erd); end
            n_cmp++; if (bus.retire_data !== ed || bus.retire_store_data !== esd) begin
                n_fail++; $display("FAIL rnd_retire_data got %h/%h want %h/%h", bus.retire_data, bus.retire_store_data, ed, esd); end
            n_cmp++; if (bus.retire_is_store !== est || bus.retire_is_branch !== ebr || bus.retire_branch_taken !== etk) begin
                n_fail++; $display("FAIL rnd_retire_flags got %b%b%b want %b%b%b", bus.retire_is_store, bus.retire_is_branch,
                    bus.retire_branch_taken, est, ebr, etk); end
            rs_exp(bus.rs1_tag, r1, d1);
            rs_exp(bus.rs2_tag, r2, d2);
            n_cmp++; if (bus.rs1_ready !== r1 || (r1 && bus.rs1_data !== d1)) begin
                n_fail++; $display("FAIL rnd_rs1 got %b/%h want %b/%h", bus.rs1_ready, bus.rs1_data, r1, d1); end
            n_cmp++; if (bus.rs2_ready !== r2 || (r2 && bus.rs2_data !== d2)) begin
                n_fail++; $display("FAIL rnd_rs2 got %b/%h want %b/%h", bus.rs2_ready, bus.rs2_data, r2, d2); end
            for (int k = 0; k < n; k++)
                $display("cycle %0d retire slot%0d rd %0d data %h store %b", cyc, k, q[k].rd, q[k].d, q[k].st);
            tick();
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        bus.flush = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            bus.alloc_valid = 1'b1;
            tick();
        end
        idle_inputs();
        #2;
        i_rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.count !== 7'd0 || bus.empty !== 1'b1 || bus.alloc_tag !== 6'd0) begin
            n_fail++; $display("FAIL async_reset got count %0d empty %b tag %0d want 0/1/0", bus.count, bus.empty, bus.alloc_tag); end
        q.delete();
        m_head = 0;
        @(negedge clk);
        i_rst_n = 1'b1;
        $display("async reset checked");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_inorder_pair();
        test_store_serial();
        test_wrap();
        test_flush();
        test_bypass();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_fifo_multi.md
Name: rob_fifo_multi

Overview:
- Parametrised reorder buffer: circular FIFO of speculative results, successor to the fixed 64-entry ROB register file.
- Owns head/tail pointers and occupancy internally.
- Accepts NUM_CDB result broadcasts per cycle and retires up to RETIRE_W entries per cycle, in order, to the architectural commit stage.
- Sits between dispatch (allocate), the CDB (complete) and the commit/store path (retire).

Parameters:
- DEPTH, 64, entry count; power of 2, >=4.
- TAG_W, $clog2(DEPTH), tag / pointer index width.
- DATA_W, 32, result and store-data width.
- NUM_CDB, 2, number of CDB update ports (1..4).
- RETIRE_W, 2, maximum retires per cycle (1 or 2).

Ports:
- clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous flush (mispredict)
- alloc_valid  in  1  dispatch requests an entry
- alloc_rd  in  5  destination architectural register
- alloc_is_store  in  1  entry is a store
- alloc_is_branch  in  1  entry is a branch
- alloc_ready  out  1  not full
- alloc_tag  out  TAG_W  tag assigned (current tail)
- cdb_valid  in  NUM_CDB  per-port completion strobe
- cdb_tag  in  NUM_CDB*TAG_W  completing tags
- cdb_result  in  NUM_CDB*DATA_W  result, or address for stores
- cdb_store_data  in  NUM_CDB*DATA_W  store data
- cdb_branch_taken  in  NUM_CDB  branch outcome
- rs1_tag, rs2_tag  in  TAG_W  operand lookup tags
- rs1_data, rs2_data  out  DATA_W  spec_data of the looked-up entry
- rs1_ready, rs2_ready  out  1  entry valid and spec_valid
- retire_stall  in  1  commit stage cannot accept
- retire_valid  out  RETIRE_W  per-slot retire strobe
- retire_rd  out  RETIRE_W*5  per-slot destination register
- retire_data  out  RETIRE_W*DATA_W  per-slot spec_data
- retire_store_data  out  RETIRE_W*DATA_W  per-slot store data
- retire_is_store, retire_is_branch, retire_branch_taken  out  RETIRE_W  per-slot flags
- count  out  TAG_W+1  occupancy
- empty  out  1  count==0

Behaviour:
- Entry fields: valid, spec_valid, rd, is_store, is_branch, branch_taken, spec_data, store_data.
- Pointers: head and tail are TAG_W+1 bits (wrap bit). Index = low TAG_W bits.
  - full = index bits equal, wrap bits differ.
  - empty = pointers equal.
- Reset (async): all entries cleared, head=tail=0, count=0. Outputs: alloc_ready=1, empty=1, retire_valid=0, alloc_tag=0, all data outputs 0.
- Allocate: on alloc_valid && alloc_ready, entry[tail] is written with valid=1, spec_valid=0 and the alloc fields; tail increments.
  - alloc_tag is combinational = tail index.
  - alloc_valid while full is ignored.
- CDB: for each port p with cdb_valid[p], entry[cdb_tag[p]] gets spec_data, store_data, branch_taken and spec_valid=1, registered.
  - Update to an entry with valid=0 is ignored.
  - Two ports with the same tag is illegal; the higher port index wins.
- Retire (combinational from registered state, committed at the clock edge):
  - slot0 valid iff !retire_stall && !empty && entry[head].valid && spec_valid.
  - slot1 (RETIRE_W=2) valid iff slot0 valid && count>=2 && entry[head+1].valid && spec_valid && !(both slots are stores). At most one store retires per cycle.
  - Retired entries are cleared (valid=0, spec_valid=0); head advances by the number retired, mod 2*DEPTH.
  - retire_* data outputs are 0 on invalid slots.
- Latency:
  - Allocate -> CDB-capable: next cycle.
  - CDB -> retire eligibility: 1 cycle (registered).
  - Retire -> slot free: next cycle.
- count_next = count + alloc_fire - retire_num. Simultaneous allocate and retire are both honoured.
- Full with retire in the same cycle: alloc_ready stays 0, because it is based on registered count.
- Pointer wrap: index DEPTH-1 -> 0; slot1 reads entry[(head+1) mod DEPTH].
- Flush: synchronous, highest priority. All valid/spec_valid cleared, head=tail=0, count=0; alloc/CDB/retire that cycle are discarded. retire_valid remains combinational during the flush cycle; the commit stage gates it with flush.
- Operand read: combinational, rsN_ready = valid && spec_valid.

Optional Feature:
- Macro ROB_CDB_BYPASS_EN.
- Defined: rsN_data/rsN_ready forward the same-cycle cdb_result when cdb_valid[p] && cdb_tag[p]==rsN_tag && entry valid (highest matching port wins), giving zero-cycle wakeup.
- Undefined: reads reflect registered state only; a result is visible one cycle after the CDB.

Test Plan:
- Reset then 64 allocations, no CDB -> tags 0..63 issued, alloc_ready=0 after the 64th, count=64; a 65th alloc_valid leaves tail unchanged.
- Allocate tags 0,1,2; CDB tag1 (0x11), then tag0 (0x10) -> no retire after tag1; the cycle after tag0 completes, slot0=0x10 and slot1=0x11 retire together, count=1.
- Two consecutive stores completed -> retire one per cycle over two cycles, retire_is_store=1 each time.
- Fill with head at 62 and complete all entries -> retires cross 63->0 correctly; empty=1 at the end, with the pointer wrap bit toggled.
- Flush asserted the same cycle as alloc_valid, a CDB on tag 3 and a retirable head -> next cycle count=0, empty=1, head=tail=0, no retire committed.
- With ROB_CDB_BYPASS_EN: rs1_tag=5 while the CDB broadcasts tag5=0xABCD -> rs1_ready=1, rs1_data=0xABCD in that same cycle. Without the macro, these appear one cycle later.
